// File: rtl/access_pkg.sv
// Shared definitions for the access lockout controller.
//   state_t        : controller FSM states
//   EV_*           : last_event codes reported to software
//   max_int()      : sizing helper for the shared window timer
package access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNLOCK = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_GRANT = 2'b01;
  localparam logic [1:0] EV_DENY  = 2'b10;
  localparam logic [1:0] EV_LOCK  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/access_edge_det.sv
// Rising-edge detector, one independent detector per bit.
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears the history register
//   sig_i : level inputs
//   rise_o: sig_i & ~previous sig_i (combinational from the registered history)
// Because the history clears to 0 in reset, an input held high across reset
// release reports an edge on the first cycle after release.
module access_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/access_lockout_ctrl.sv
// Access lockout controller: turns ID-comparator grant/deny levels into an
// actuator unlock window, counts consecutive denials and enters a timed
// lockout (with a sticky interrupt) after MAX_FAILS of them.
//   clk            : system clock
//   rst            : asynchronous active-high reset
//   access_granted : ID-match level
//   access_denied  : ID-mismatch level
//   irq_ack        : software acknowledge level, clears irq
//   unlock         : actuator enable during the unlock window
//   locked         : high during lockout
//   irq            : pending interrupt
//   fail_count     : consecutive denial count
//   last_event     : EV_NONE / EV_GRANT / EV_DENY / EV_LOCK
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a grant or deny edge
// ST_UNLOCK | unlock window open, timer counts down to the window end
// ST_LOCKED | lockout, all access events ignored until the timer expires
module access_lockout_ctrl
  import access_pkg::*;
#(
  parameter int MAX_FAILS     = 3,
  parameter int LOCK_CYCLES   = 1000,
  parameter int UNLOCK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       access_granted,
  input  logic       access_denied,
  input  logic       irq_ack,
  output logic       unlock,
  output logic       locked,
  output logic       irq,
  output logic [3:0] fail_count,
  output logic [1:0] last_event
);

  localparam int TW = $clog2(max_int(LOCK_CYCLES, UNLOCK_CYCLES) + 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [4:0]    MAX_FAILS_W = 5'(MAX_FAILS);

  logic grant_ev;
  logic deny_ev;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    fail_count_q, fail_count_d;
  logic [1:0]    last_event_q, last_event_d;
  logic          unlock_q, unlock_d;
  logic          locked_q, locked_d;
  logic          irq_q, irq_d;

  logic [4:0]    fail_inc;
  logic          hits_max;

  access_edge_det #(.W(1)) u_grant_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (access_granted),
    .rise_o (grant_ev)
  );

  access_edge_det #(.W(1)) u_deny_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (access_denied),
    .rise_o (deny_ev)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fail_count_d = fail_count_q;
    last_event_d = last_event_q;
    unlock_d     = unlock_q;
    locked_d     = locked_q;
    // Acknowledge clears; a lockout entry below overrides it (set wins).
    irq_d        = irq_ack ? 1'b0 : irq_q;

    fail_inc = {1'b0, fail_count_q} + 5'd1;
    hits_max = (fail_inc >= MAX_FAILS_W);

    unique case (state_q)
      ST_IDLE, ST_UNLOCK: begin
        // Deny is checked first so a simultaneous grant never opens the door.
        if (deny_ev) begin
          unlock_d = 1'b0;
          if (hits_max) begin
            state_d      = ST_LOCKED;
            locked_d     = 1'b1;
            irq_d        = 1'b1;
            fail_count_d = 4'd0;
            timer_d      = LOCK_LOAD;
            last_event_d = EV_LOCK;
          end else begin
            state_d      = ST_IDLE;
            timer_d      = '0;
            fail_count_d = fail_inc[3:0];
            last_event_d = EV_DENY;
          end
        end else if (grant_ev) begin
          // In ST_UNLOCK this reloads the timer and extends the window.
          state_d      = ST_UNLOCK;
          unlock_d     = 1'b1;
          timer_d      = UNLOCK_LOAD;
          fail_count_d = 4'd0;
          last_event_d = EV_GRANT;
        end else if (state_q == ST_UNLOCK) begin
          if (timer_q <= TIMER_ONE) begin
            state_d  = ST_IDLE;
            unlock_d = 1'b0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end

      ST_LOCKED: begin
        if (timer_q <= TIMER_ONE) begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        unlock_d = 1'b0;
        locked_d = 1'b0;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      fail_count_q <= 4'd0;
      last_event_q <= EV_NONE;
      unlock_q     <= 1'b0;
      locked_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_count_q <= fail_count_d;
      last_event_q <= last_event_d;
      unlock_q     <= unlock_d;
      locked_q     <= locked_d;
      irq_q        <= irq_d;
    end
  end

  assign unlock     = unlock_q;
  assign locked     = locked_q;
  assign irq        = irq_q;
  assign fail_count = fail_count_q;
  assign last_event = last_event_q;

endmodule

// File: tb/tb_access_lockout_ctrl.sv
// Bench for access_lockout_ctrl with MAX_FAILS=3, LOCK_CYCLES=20,
// UNLOCK_CYCLES=5: a directed vector table, hand-written corner sequences,
// then random stimulus against a cycle-count reference model.
module tb_access_lockout_ctrl;

  localparam int MF = 3;
  localparam int LC = 20;
  localparam int UC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       access_granted = 1'b0;
  logic       access_denied  = 1'b0;
  logic       irq_ack        = 1'b0;
  logic       unlock, locked, irq;
  logic [3:0] fail_count;
  logic [1:0] last_event;

  int n_checks = 0;
  int n_errors = 0;

  access_lockout_ctrl #(
    .MAX_FAILS     (MF),
    .LOCK_CYCLES   (LC),
    .UNLOCK_CYCLES (UC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .access_granted (access_granted),
    .access_denied  (access_denied),
    .irq_ack        (irq_ack),
    .unlock         (unlock),
    .locked         (locked),
    .irq            (irq),
    .fail_count     (fail_count),
    .last_event     (last_event)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference model: remaining window lengths and counters as plain integers.
  int m_prev_g, m_prev_d, m_unlock_left, m_lock_left, m_fails, m_irq, m_last;

  function automatic void model_reset();
    m_prev_g = 0; m_prev_d = 0; m_unlock_left = 0; m_lock_left = 0;
    m_fails = 0; m_irq = 0; m_last = 0;
  endfunction

  function automatic void model_step(input int g, input int d, input int a);
    int ge, de;
    ge = (g != 0 && m_prev_g == 0) ? 1 : 0;
    de = (d != 0 && m_prev_d == 0) ? 1 : 0;
    m_prev_g = g;
    m_prev_d = d;
    if (a != 0) m_irq = 0;
    if (m_lock_left > 0) begin
      m_lock_left = m_lock_left - 1;
    end else if (de != 0) begin
      m_unlock_left = 0;
      m_fails = m_fails + 1;
      if (m_fails == MF) begin
        m_fails = 0; m_lock_left = LC; m_irq = 1; m_last = 3;
      end else begin
        m_last = 2;
      end
    end else if (ge != 0) begin
      m_unlock_left = UC; m_fails = 0; m_last = 1;
    end else if (m_unlock_left > 0) begin
      m_unlock_left = m_unlock_left - 1;
    end
  endfunction

  function automatic logic [10:0] model_out();
    return {(m_unlock_left > 0) ? 1'b1 : 1'b0, (m_lock_left > 0) ? 1'b1 : 1'b0,
            m_irq[0], 4'(m_fails), 2'(m_last)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {unlock, locked, irq, fail_count, last_event};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, advance past the rising edge, step the model.
  task automatic tick(input logic g, input logic d, input logic a);
    access_granted = g;
    access_denied  = d;
    irq_ack        = a;
    @(posedge clk);
    #1;
    model_step(int'(g), int'(d), int'(a));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    access_granted = 1'b0;
    access_denied  = 1'b0;
    irq_ack        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       g, d, a;
    logic       eu, el, ei;
    logic [3:0] efc;
    logic [1:0] elast;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic g, input logic d, input logic a,
                              input logic eu, input logic el, input logic ei,
                              input logic [3:0] efc, input logic [1:0] elast);
    vec_t v;
    v.g = g; v.d = d; v.a = a; v.eu = eu; v.el = el; v.ei = ei;
    v.efc = efc; v.elast = elast;
    return v;
  endfunction

  int cnt_u, cnt_l;

  initial begin
    // Reset state, checked while reset is still held.
    #1;
    check("reset_outputs", 32'(dut_out()), 32'h0);

    //                 g     d     a     unl   lck   irq   fc    last
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd2)); // both -> deny
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1)); // grant
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1)); // level, no edge
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1)); // 5th high cycle
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 2'd2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd3)); // lockout
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'd3)); // ack
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd3)); // grant ignored
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd3)); // deny ignored

    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].g, tbl[i].d, tbl[i].a);
      check($sformatf("table_row_%0d", i), 32'(dut_out()),
            32'({tbl[i].eu, tbl[i].el, tbl[i].ei, tbl[i].efc, tbl[i].elast}));
    end

    // Lockout duration with a grant pulse inside it.
    do_reset();
    tick(1'b0, 1'b1, 1'b0); check("deny1_count", 32'(fail_count), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); check("deny2_count", 32'(fail_count), 32'd2);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("lock_entry", 32'({locked, irq, last_event}), 32'({1'b1, 1'b1, 2'd3}));
    cnt_l = 1; cnt_u = 0;
    for (int k = 0; k < 40; k++) begin
      tick((k == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      cnt_l += int'(locked);
      cnt_u += int'(unlock);
    end
    check("lock_cycles", 32'(cnt_l), 32'(LC));
    check("no_unlock_in_lock", 32'(cnt_u), 32'd0);
    check("irq_sticky", 32'(irq), 32'd1);
    tick(1'b0, 1'b0, 1'b1); check("irq_ack_clears", 32'(irq), 32'd0);

    // Lockout entry coinciding with acknowledge: set wins.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    check("irq_set_wins", 32'({locked, irq}), 32'({1'b1, 1'b1}));
    tick(1'b0, 1'b0, 1'b0); check("irq_held", 32'(irq), 32'd1);

    // Second grant three cycles after the first extends the window to 8 cycles.
    do_reset();
    cnt_u = 0;
    tick(1'b1, 1'b0, 1'b0); cnt_u += int'(unlock);
    tick(1'b0, 1'b0, 1'b0); cnt_u += int'(unlock);
    tick(1'b0, 1'b0, 1'b0); cnt_u += int'(unlock);
    tick(1'b1, 1'b0, 1'b0); cnt_u += int'(unlock);
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 1'b0, 1'b0); cnt_u += int'(unlock);
    end
    check("grant_extend_len", 32'(cnt_u), 32'd8);

    // Deny two cycles after a grant ends the window at once.
    do_reset();
    cnt_u = 0;
    tick(1'b1, 1'b0, 1'b0); cnt_u += int'(unlock);
    tick(1'b0, 1'b0, 1'b0); cnt_u += int'(unlock);
    tick(1'b0, 1'b1, 1'b0); cnt_u += int'(unlock);
    check("deny_in_unlock", 32'({unlock, fail_count, last_event}), 32'({1'b0, 4'd1, 2'd2}));
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 1'b0); cnt_u += int'(unlock);
    end
    check("deny_cut_len", 32'(cnt_u), 32'd2);

    // Reset ten cycles into lockout, deny held high across release.
    do_reset();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b0, 1'b0);
    check("lock_before_rst", 32'({locked, irq}), 32'({1'b1, 1'b1}));
    #2;
    rst = 1'b1;
    access_denied = 1'b1;
    #1;
    check("rst_async_clear", 32'(dut_out()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b1, 1'b0);
    check("edge_after_release", 32'({fail_count, last_event, locked, unlock}),
          32'({4'd1, 2'd2, 1'b0, 1'b0}));

    // Random stimulus against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic rg, rd, ra;
      rg = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 4) == 0);
      ra = ($urandom_range(0, 9) == 0);
      tick(rg, rd, ra);
      check($sformatf("random_cycle_%0d", k), 32'(dut_out()), 32'(model_out()));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/access_lockout_ctrl.md
ACCESS_LOCKOUT_CTRL -- requirements
Module: access_lockout_ctrl

Interface
REQ-001 SHALL have parameter MAX_FAILS, default 3: consecutive denials (1..15) that trigger lockout.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1000: lockout duration in clk cycles (>=2).
REQ-003 SHALL have parameter UNLOCK_CYCLES, default 50: unlock pulse length in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port access_granted  input  1  ID-match result from the ID comparator (level).
REQ-007 SHALL have port access_denied  input  1  ID-mismatch result from the ID comparator (level).
REQ-008 SHALL have port irq_ack  input  1  software acknowledge (level, from S00 register).
REQ-009 SHALL have port unlock  output  1  actuator enable, high for the unlock window.
REQ-010 SHALL have port locked  output  1  high while in lockout.
REQ-011 SHALL have port irq  output  1  pending-interrupt level to the processor.
REQ-012 SHALL have port fail_count  output  4  current consecutive-denial count.
REQ-013 SHALL have port last_event  output  2  00 none, 01 grant, 10 deny, 11 lockout entered.

Function
REQ-014 SHALL detect events as rising edges: grant_ev = access_granted & ~prev, deny_ev likewise; prev registered every cycle.
REQ-015 SHALL implement FSM states IDLE, UNLOCK, LOCKED; all outputs registered; response visible one cycle after the edge sample.
REQ-016 IDLE + grant_ev: go UNLOCK, unlock=1, load timer UNLOCK_CYCLES, fail_count=0, last_event=01.
REQ-017 IDLE + deny_ev with fail_count+1 < MAX_FAILS: stay IDLE, fail_count+1, last_event=10.
REQ-018 IDLE + deny_ev with fail_count+1 = MAX_FAILS: go LOCKED, locked=1, irq=1, fail_count=0, load timer LOCK_CYCLES, last_event=11.
REQ-019 Simultaneous grant_ev and deny_ev SHALL be treated as deny_ev only (fail-secure).
REQ-020 UNLOCK: timer decrements each cycle; unlock deasserts and state returns IDLE the cycle the timer reaches 0; unlock high exactly UNLOCK_CYCLES cycles.
REQ-021 UNLOCK + grant_ev SHALL reload the timer (window extends); deny_ev in UNLOCK SHALL end the window immediately (unlock=0, go IDLE) and count as per REQ-017/018.
REQ-022 LOCKED: grant_ev and deny_ev SHALL be ignored (no count, no last_event change); locked high exactly LOCK_CYCLES cycles, then IDLE.
REQ-023 irq SHALL remain high until a cycle with irq_ack=1; if lockout entry and irq_ack coincide, irq SHALL be 1 (set wins).
REQ-024 fail_count SHALL never exceed MAX_FAILS-1; timer width SHALL be clog2 of max(LOCK_CYCLES, UNLOCK_CYCLES)+1 bits, no wrap.

Reset
REQ-025 rst high SHALL immediately force IDLE, unlock=0, locked=0, irq=0, fail_count=0, last_event=00, timer=0, prev edge registers=0.
REQ-026 Reset mid-UNLOCK or mid-LOCKED SHALL abort the window with no residual pulse; an input held high across reset release SHALL count as an edge on the first cycle.

Structure
REQ-027 Package access_pkg SHALL hold the FSM state enum and last_event code constants.
REQ-028 Edge detection SHALL be one sub-module access_edge_det (per-bit rising edge, async reset), instantiated for grant and deny.

Verification (MAX_FAILS=3, LOCK_CYCLES=20, UNLOCK_CYCLES=5)
REQ-029 Grant pulse from IDLE -> unlock high exactly 5 cycles starting 1 cycle later, last_event=01, fail_count=0.
REQ-030 Three deny pulses -> fail_count 1,2 then locked=1, irq=1, last_event=11; locked high exactly 20 cycles; grant pulse during lockout -> no unlock.
REQ-031 irq pending, irq_ack=1 one cycle -> irq=0 next cycle; lockout entry coinciding with irq_ack -> irq stays 1.
REQ-032 Grant and deny rising in same cycle with fail_count=0 -> fail_count=1, unlock stays 0.
REQ-033 Grant at t, second grant at t+3 -> unlock high 8 cycles total; deny at t+2 instead -> unlock drops at t+3, fail_count=1.
REQ-034 rst pulse at cycle 10 of lockout -> locked=0, irq=0 same cycle; access_denied held high through release -> fail_count=1 one cycle after release.
